// File: rtl/alu_cmd_pkg.sv
// Shared types for the command-stream ALU: opcode and FSM state
// encodings plus the opcode legality helper.
package alu_cmd_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } opcode_e;

    typedef enum logic [1:0] {
        S_OP,
        S_A,
        S_B,
        S_RES
    } state_e;

    // Only the low three bits are checked here; the caller must
    // separately require the upper command bits to be zero.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

endpackage

// File: rtl/ripple_add_sub.sv
// Ripple-carry adder/subtractor built from a chain of full adders.
// Ports: a, b operands; sub selects a+~b+1; sum result; cout carry-out.
module ripple_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_b;

    // Subtraction as a + ~b + 1: invert b, inject sub as carry-in.
    assign w_b    = b ^ {WIDTH{sub}};
    assign w_c[0] = sub;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign sum[i]    = a[i] ^ w_b[i] ^ w_c[i];
            assign w_c[i+1]  = (a[i] & w_b[i])
                             | (w_c[i] & (a[i] ^ w_b[i]));
        end
    endgenerate

    assign cout = w_c[WIDTH];

endmodule

// File: rtl/stream_alu_sequencer.sv
// Sequential command-stream ALU: takes {opcode, A, B} words on a
// valid/ready input, returns one result word + flag on a valid/ready
// output.
// Ports: clk, rst_n (sync, active-low); in_data/in_valid/in_ready
// command stream; res_data/res_flag/res_valid/res_ready result
// stream; err_op illegal-opcode pulse; busy (not idle in S_OP);
// cmd_count completed commands.
module stream_alu_sequencer
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_flag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             err_op,
    output logic             busy,
    output logic [CNT_W-1:0] cmd_count
);

    state_e           r_state;
    opcode_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_res;
    logic             r_flag;
    logic             r_in_ready;
    logic             r_res_valid;
    logic             r_err_op;
    logic             r_busy;
    logic [CNT_W-1:0] r_cmd_count;

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_result;
    logic             w_flag;
    logic             w_legal;

    // Upper command bits must be zero for an opcode to be legal.
    assign w_legal = ((in_data >> 3) == '0)
                   && is_legal_op(in_data[2:0]);

    // B comes straight from the stream so the result is registered
    // on the same edge that accepts B.
    ripple_add_sub #(.WIDTH(WIDTH)) u_addsub (
        .a    (r_a),
        .b    (in_data),
        .sub  (r_op == OP_SUB),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_result = '0;
        w_flag   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_result = w_sum;
                w_flag   = w_cout;
            end
            OP_SUB: begin
                w_result = w_sum;
                w_flag   = ~w_cout;
            end
            OP_AND:  w_result = r_a & in_data;
            OP_OR:   w_result = r_a | in_data;
            OP_XOR:  w_result = r_a ^ in_data;
            default: w_result = '0;
        endcase
    end

    // In S_OP/S_A/S_B in_ready is 1, so in_valid alone marks a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_OP;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_res       <= '0;
            r_flag      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
            r_err_op    <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_count <= '0;
        end else begin
            r_err_op <= 1'b0;
            case (r_state)
                S_OP: begin
                    if (in_valid) begin
                        if (w_legal) begin
                            r_op    <= opcode_e'(in_data[2:0]);
                            r_state <= S_A;
                            r_busy  <= 1'b1;
                        end else begin
                            r_err_op <= 1'b1;
                        end
                    end
                end
                S_A: begin
                    if (in_valid) begin
                        r_a     <= in_data;
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (in_valid) begin
                        r_res       <= w_result;
                        r_flag      <= w_flag;
                        r_in_ready  <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RES;
                    end
                end
                S_RES: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cmd_count <= r_cmd_count + 1'b1;
                        r_state     <= S_OP;
                    end
                end
                default: r_state <= S_OP;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign res_data  = r_res;
    assign res_flag  = r_flag;
    assign res_valid = r_res_valid;
    assign err_op    = r_err_op;
    assign busy      = r_busy;
    assign cmd_count = r_cmd_count;

endmodule

// File: tb/tb_stream_alu_sequencer.sv
// Scoreboard bench for stream_alu_sequencer: directed scenarios
// followed by a randomised stream against a reference model.
module tb_stream_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  res_data;
    logic        res_flag;
    logic        res_valid;
    logic        res_ready;
    logic        err_op;
    logic        busy;
    logic [15:0] cmd_count;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] exp_cnt = '0;
    logic [8:0]  sb[$];

    always #5 clk = ~clk;

    stream_alu_sequencer #(.WIDTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_data  (res_data),
        .res_flag  (res_flag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err_op    (err_op),
        .busy      (busy),
        .cmd_count (cmd_count)
    );

    // Reference model: returns {flag, result}.
    function automatic logic [8:0] model(
        input logic [7:0] op,
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [8:0] s;
        case (op)
            8'd0: s = {1'b0, a} + {1'b0, b};
            8'd1: s = {(a < b), 8'(a - b)};
            8'd2: s = {1'b0, a & b};
            8'd3: s = {1'b0, a | b};
            8'd4: s = {1'b0, a ^ b};
            default: s = '0;
        endcase
        return s;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send_word(input logic [7:0] w);
        int t;
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_word timeout word=%h", w);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(
        input logic [7:0] op,
        input logic [7:0] a,
        input logic [7:0] b
    );
        send_word(op);
        send_word(a);
        sb.push_back(model(op, a, b));
        send_word(b);
    endtask

    task automatic get_result(input string nm);
        int t;
        logic [8:0] e;
        t = 0;
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_total++;
        if (!res_valid || sb.size() == 0) begin
            $display("FAIL %s no result valid=%b sb=%0d",
                     nm, res_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if ({res_flag, res_data} !== e)
                $display("FAIL %s got flag=%b data=%h exp flag=%b data=%h",
                         nm, res_flag, res_data, e[8], e[7:0]);
            else
                n_pass++;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            exp_cnt++;
        end
    endtask

    task automatic test_reset;
        n_total++;
        if ({in_ready, res_valid, res_data, res_flag, err_op, busy,
             cmd_count} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0})
            $display("FAIL reset rdy=%b rv=%b d=%h f=%b e=%b b=%b c=%h exp 1 0 00 0 0 0 0000",
                     in_ready, res_valid, res_data, res_flag, err_op,
                     busy, cmd_count);
        else
            n_pass++;
    endtask

    task automatic test_add_basic;
        send_cmd(8'h00, 8'h05, 8'h03);
        n_total++;
        if (res_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL add_latency rv=%b rdy=%b busy=%b exp 1 0 1",
                     res_valid, in_ready, busy);
        else
            n_pass++;
        res_ready = 1'b1;
        get_result("add_basic");
        n_total++;
        if (res_valid !== 1'b0 || cmd_count !== exp_cnt)
            $display("FAIL add_done rv=%b cnt=%h exp 0 %h",
                     res_valid, cmd_count, exp_cnt);
        else
            n_pass++;
    endtask

    task automatic test_arith;
        send_cmd(8'h00, 8'hFF, 8'h02);
        get_result("add_carry");
        send_cmd(8'h01, 8'h03, 8'h05);
        get_result("sub_borrow");
        send_cmd(8'h01, 8'h05, 8'h03);
        get_result("sub_noborrow");
    endtask

    task automatic test_logic_illegal;
        logic [15:0] c0;
        send_cmd(8'h04, 8'hF0, 8'h3C);
        get_result("xor");
        c0 = exp_cnt;
        send_word(8'h07);
        n_total++;
        if (err_op !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL illegal_07 err=%b rdy=%b busy=%b exp 1 1 0",
                     err_op, in_ready, busy);
        else
            n_pass++;
        send_word(8'h09);
        n_total++;
        if (err_op !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL illegal_09 err=%b rdy=%b busy=%b exp 1 1 0",
                     err_op, in_ready, busy);
        else
            n_pass++;
        @(negedge clk);
        n_total++;
        if (err_op !== 1'b0 || res_valid !== 1'b0 || cmd_count !== c0)
            $display("FAIL illegal_after err=%b rv=%b cnt=%h exp 0 0 %h",
                     err_op, res_valid, cmd_count, c0);
        else
            n_pass++;
    endtask

    task automatic test_backpressure;
        logic [7:0] d0;
        send_cmd(8'h03, 8'hA0, 8'h05);
        d0 = res_data;
        in_valid = 1'b1;
        in_data  = 8'h02;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if (res_valid !== 1'b1 || res_data !== d0 ||
                in_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL stall%0d rv=%b d=%h rdy=%b busy=%b exp 1 %h 0 1",
                         i, res_valid, res_data, in_ready, busy, d0);
            else
                n_pass++;
        end
        get_result("stall_or");
        n_total++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL stall_release busy=%b rdy=%b exp 0 1",
                     busy, in_ready);
        else
            n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        n_total++;
        if (busy !== 1'b1)
            $display("FAIL stall_next_op busy=%b exp 1", busy);
        else
            n_pass++;
        send_word(8'h3C);
        sb.push_back(model(8'h02, 8'h3C, 8'h0F));
        send_word(8'h0F);
        get_result("stall_and");
    endtask

    task automatic test_reset_mid;
        send_word(8'h00);
        send_word(8'h11);
        rst_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({in_ready, res_valid, res_data, res_flag, err_op, busy,
             cmd_count} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0})
            $display("FAIL reset_mid rdy=%b rv=%b d=%h f=%b e=%b b=%b c=%h exp 1 0 00 0 0 0 0000",
                     in_ready, res_valid, res_data, res_flag, err_op,
                     busy, cmd_count);
        else
            n_pass++;
        rst_n   = 1'b1;
        exp_cnt = '0;
        send_cmd(8'h00, 8'h80, 8'h90);
        get_result("post_reset_add");
        n_total++;
        if (cmd_count !== 16'd1)
            $display("FAIL post_reset_cnt got %h exp 0001", cmd_count);
        else
            n_pass++;
    endtask

    task automatic test_random;
        logic [7:0] words[$];
        logic [8:0] e;
        int idx;
        int cyc;
        bit rr;
        for (int k = 0; k < 1000; k++) begin
            words.push_back(8'($urandom_range(0, 4)));
            words.push_back(8'($urandom));
            words.push_back(8'($urandom));
        end
        idx = 0;
        cyc = 0;
        while ((idx < words.size() || sb.size() != 0) && cyc < 40000) begin
            rr = ($urandom_range(0, 2) != 0);
            res_ready = rr;
            if (res_valid && rr) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL rand unexpected result d=%h", res_data);
                end else begin
                    e = sb.pop_front();
                    if ({res_flag, res_data} !== e)
                        $display("FAIL rand got flag=%b data=%h exp flag=%b data=%h",
                                 res_flag, res_data, e[8], e[7:0]);
                    else
                        n_pass++;
                end
                exp_cnt++;
            end
            if (in_ready && idx < words.size() &&
                $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = words[idx];
                if (idx % 3 == 2)
                    sb.push_back(model(words[idx-2], words[idx-1],
                                       words[idx]));
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        res_ready = 1'b0;
        n_total++;
        if (cyc >= 40000)
            $display("FAIL rand timeout idx=%0d sb=%0d", idx, sb.size());
        else if (cmd_count !== exp_cnt)
            $display("FAIL rand_cnt got %h exp %h", cmd_count, exp_cnt);
        else
            n_pass++;
    endtask

    task automatic test_wrap;
        force dut.r_cmd_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_cmd_count;
        @(negedge clk);
        n_total++;
        if (cmd_count !== 16'hFFFF)
            $display("FAIL wrap_preset got %h exp ffff", cmd_count);
        else
            n_pass++;
        send_cmd(8'h02, 8'hFF, 8'h0F);
        get_result("wrap_and");
        n_total++;
        if (cmd_count !== 16'h0000)
            $display("FAIL wrap got %h exp 0000", cmd_count);
        else
            n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_add_basic();
        res_ready = 1'b0;
        test_arith();
        test_logic_illegal();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
